// File: rtl/yutorina_exc_ctrl.sv
// yutorina_exc_ctrl: exception/interrupt/ERET control with nested EPC stack and SPR file
// Ports: clk, rst (sync, active-high); i_busy/d_busy combine into stall; eret from ID;
//   mem_valid, exp_code, mem_pc, spr_we, w_addr, w_data from MEM; irq level lines;
//   r_addr -> r_data (combinational SPR read); flush/id_flush one-cycle pulses with
//   new_pc as redirect target; mode (0 kernel, 1 user).
// Optional: define YUTORINA_EXC_CTRL_TIMER_EN to add the CMP SPR and the timer interrupt.
module yutorina_exc_ctrl #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IRQ_N = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_busy,
  input  logic              d_busy,
  input  logic              eret,
  input  logic              mem_valid,
  input  logic [3:0]        exp_code,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic [IRQ_N-1:0]  irq,
  input  logic              spr_we,
  input  logic [4:0]        w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [4:0]        r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              stall,
  output logic              flush,
  output logic              id_flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              mode
);
`ifdef YUTORINA_EXC_CTRL_TIMER_EN
  localparam int SRC_N = IRQ_N + 1;
`else
  localparam int SRC_N = IRQ_N;
`endif
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int IX_W = $clog2(DEPTH);
  localparam int CAUSE_W = 6;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  vector;
  logic [SRC_N-1:0]   imask, src, pend;
  logic               ie, ovf;
  logic [SP_W-1:0]    sp;
  logic [CAUSE_W-1:0] cause, trap_cause;
  logic [ADDR_W-1:0]  epc_stk [DEPTH];
  logic [CAUSE_W-1:0] cause_stk [DEPTH];
  logic               mode_stk [DEPTH];
  logic               ie_stk [DEPTH];
  logic [IX_W-1:0]    top, below, push_ix;
  logic               empty, full, take_eret, take_exc, take_irq, trap, take_spr;
  logic [4:0]         irq_k;

  assign stall = i_busy | d_busy;
  assign empty = sp == '0;
  assign full = sp == SP_W'(DEPTH);
  assign top = IX_W'(sp - SP_W'(1));
  assign below = IX_W'(sp - SP_W'(2));
  assign push_ix = IX_W'(sp);

`ifdef YUTORINA_EXC_CTRL_TIMER_EN
  logic [DATA_W-1:0] cmp;
  logic              tpend;
  assign src = {tpend, irq};
  // The compare match is captured even while stalled so a hit is never lost.
  always_ff @(posedge clk)
    if (rst) begin
      cmp <= '0;
      tpend <= 1'b0;
    end else if (take_spr && w_addr == 5'd10) begin
      cmp <= w_data;
      tpend <= 1'b0;
    end else if (cmp != '0 && cnt[DATA_W-1:0] == cmp) tpend <= 1'b1;
`else
  assign src = irq;
`endif
  assign pend = src & imask;

  // Lowest pending index wins.
  always_comb begin
    irq_k = '0;
    for (int i = SRC_N - 1; i >= 0; i--) if (pend[i]) irq_k = 5'(i);
  end

  // One event per cycle: ERET > sync exception > interrupt > SPR write.
  assign take_eret = !stall && eret;
  assign take_exc = !stall && !eret && mem_valid && exp_code != 4'd0;
  assign take_irq = !stall && !eret && mem_valid && exp_code == 4'd0 && ie && |pend;
  assign trap = take_exc || take_irq;
  assign take_spr = !stall && !eret && mem_valid && spr_we && !trap;
  assign trap_cause = take_exc ? CAUSE_W'(exp_code) : CAUSE_W'(16) + CAUSE_W'(irq_k);

  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      flush <= 1'b0;
      id_flush <= 1'b0;
      new_pc <= '0;
      mode <= 1'b0;
      vector <= '0;
      imask <= '0;
      ie <= 1'b0;
      ovf <= 1'b0;
      sp <= '0;
      cause <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      flush <= take_eret || trap || take_spr;
      id_flush <= take_eret;
      new_pc <= take_eret ? (empty ? '0 : epc_stk[top]) : trap ? vector : take_spr ? mem_pc + ADDR_W'(1) : '0;
      if (take_eret) begin
        mode <= !empty && mode_stk[top];
        if (!empty) begin
          ie <= ie_stk[top];
          cause <= sp > SP_W'(1) ? cause_stk[below] : '0;
          sp <= sp - SP_W'(1);
        end
      end
      // A full stack drops the new frame but still vectors; ovf records the loss.
      if (trap) begin
        mode <= 1'b0;
        ie <= 1'b0;
        cause <= trap_cause;
        ovf <= ovf || full;
        sp <= full ? sp : sp + SP_W'(1);
      end
      if (take_spr) begin
        if (w_addr == 5'd4) vector <= w_data[ADDR_W+1:2];
        if (w_addr == 5'd5) mode <= w_data[0];
        if (w_addr == 5'd7) imask <= w_data[SRC_N-1:0];
        if (w_addr == 5'd9) begin
          ie <= w_data[0];
          ovf <= ovf && w_data[1];
        end
      end
    end

  always_ff @(posedge clk)
    if (trap && !full) begin
      epc_stk[push_ix] <= mem_pc;
      mode_stk[push_ix] <= mode;
      ie_stk[push_ix] <= ie;
      cause_stk[push_ix] <= trap_cause;
    end else if (take_spr && w_addr == 5'd1 && !empty) epc_stk[top] <= w_data[ADDR_W+1:2];

  always_comb begin
    case (r_addr)
      5'd0: r_data = DATA_W'({mem_pc, 2'b00});
      5'd1: r_data = empty ? '0 : DATA_W'({epc_stk[top], 2'b00});
      5'd2: r_data = cnt[DATA_W-1:0];
      5'd3: r_data = DATA_W'(cnt[CNT_W-1:DATA_W]);
      5'd4: r_data = DATA_W'({vector, 2'b00});
      5'd5: r_data = DATA_W'(mode);
      5'd6: r_data = DATA_W'(cause);
      5'd7: r_data = DATA_W'(imask);
      5'd8: r_data = DATA_W'(pend);
      5'd9: r_data = DATA_W'({sp, ovf, ie});
`ifdef YUTORINA_EXC_CTRL_TIMER_EN
      5'd10: r_data = cmp;
`endif
      default: r_data = '0;
    endcase
  end
endmodule

// File: tb/tb_yutorina_exc_ctrl.sv
// tb_yutorina_exc_ctrl: randomized scoreboard bench for yutorina_exc_ctrl
module tb_yutorina_exc_ctrl;
  localparam int DEPTH = 4;
`ifdef YUTORINA_EXC_CTRL_TIMER_EN
  localparam int SRC_N = 9;
`else
  localparam int SRC_N = 8;
`endif
  logic clk = 0, rst = 1, i_busy = 0, d_busy = 0, eret = 0, mem_valid = 0, spr_we = 0;
  logic [3:0] exp_code = 0;
  logic [29:0] mem_pc = 0;
  logic [7:0] irq = 0;
  logic [4:0] w_addr = 0, r_addr = 0;
  logic [31:0] w_data = 0;
  logic [31:0] r_data;
  logic stall, flush, id_flush, mode;
  logic [29:0] new_pc;
  typedef struct packed {logic [29:0] pc; logic idf; logic m;} exp_t;
  typedef struct packed {logic [29:0] epc; logic m; logic ie; logic [5:0] c;} frame_t;
  exp_t sb[$];
  frame_t stk[$];
  exp_t mon_x;
  logic m_mode, m_ie, m_ovf;
  logic [29:0] m_vec;
  logic [SRC_N-1:0] m_imask;
  logic [5:0] m_cause;
  logic [31:0] m_cmp, m_wcnt;
  logic [63:0] m_cnt;
  int passed = 0, total = 0;

  yutorina_exc_ctrl dut (.clk(clk), .rst(rst), .i_busy(i_busy), .d_busy(d_busy), .eret(eret),
    .mem_valid(mem_valid), .exp_code(exp_code), .mem_pc(mem_pc), .irq(irq), .spr_we(spr_we),
    .w_addr(w_addr), .w_data(w_data), .r_addr(r_addr), .r_data(r_data), .stall(stall),
    .flush(flush), .id_flush(id_flush), .new_pc(new_pc), .mode(mode));

  always #5 clk = ~clk;

  always @(posedge clk) m_cnt <= rst ? 64'd0 : m_cnt + 64'd1;

  always @(negedge clk)
    if (flush) begin
      total++;
      if (sb.size() == 0) $display("FAIL unexpected_flush new_pc=%h id_flush=%b", new_pc, id_flush);
      else begin
        mon_x = sb.pop_front();
        if (new_pc === mon_x.pc && id_flush === mon_x.idf && mode === mon_x.m) passed++;
        else $display("FAIL redirect got pc=%h idf=%b mode=%b want pc=%h idf=%b mode=%b",
                      new_pc, id_flush, mode, mon_x.pc, mon_x.idf, mon_x.m);
      end
    end else if (id_flush) begin
      total++;
      $display("FAIL stray_id_flush got=1 want=0");
    end

  function automatic logic [4:0] lowest(input logic [SRC_N-1:0] p);
    for (int i = 0; i < SRC_N; i++) if (p[i]) return 5'(i);
    return 5'd0;
  endfunction

  // Timer pending: some cycle since the CMP write had cnt == CMP.
  function automatic logic tp_now();
`ifdef YUTORINA_EXC_CTRL_TIMER_EN
    return m_cmp != 0 && (m_cmp - m_wcnt - 32'd1) < (m_cnt[31:0] - m_wcnt - 32'd1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [SRC_N-1:0] m_pend(input logic [7:0] ir);
    return SRC_N'({tp_now(), ir}) & m_imask;
  endfunction

  function automatic logic [31:0] m_spr(input logic [4:0] a);
    case (a)
      5'd1: return stk.size() != 0 ? {stk[stk.size()-1].epc, 2'b00} : 32'd0;
      5'd2: return m_cnt[31:0];
      5'd3: return m_cnt[63:32];
      5'd4: return {m_vec, 2'b00};
      5'd5: return {31'd0, m_mode};
      5'd6: return {26'd0, m_cause};
      5'd7: return 32'(m_imask);
      5'd8: return 32'(m_pend(8'd0));
      5'd9: return {27'd0, 3'(stk.size()), m_ovf, m_ie};
`ifdef YUTORINA_EXC_CTRL_TIMER_EN
      5'd10: return m_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", nm, got, want);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] want);
    r_addr = a;
    @(negedge clk);
    chk($sformatf("spr_read[%0d]", a), r_data, want);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic b, input logic e, input logic mv, input logic [3:0] code,
                       input logic [29:0] pc, input logic [7:0] ir, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    frame_t f;
    logic [5:0] c;
    logic [SRC_N-1:0] p;
    d_busy = b; eret = e; mem_valid = mv; exp_code = code; mem_pc = pc;
    irq = ir; spr_we = we; w_addr = wa; w_data = wd;
    p = m_pend(ir);
    if (!b) begin
      if (e) begin
        if (stk.size() == 0) begin
          m_mode = 0;
          sb.push_back('{30'd0, 1'b1, 1'b0});
        end else begin
          f = stk.pop_back();
          m_mode = f.m;
          m_ie = f.ie;
          m_cause = stk.size() != 0 ? stk[stk.size()-1].c : 6'd0;
          sb.push_back('{f.epc, 1'b1, f.m});
        end
      end else if (mv && (code != 0 || (m_ie && p != 0))) begin
        c = code != 0 ? {2'b00, code} : 6'd16 + 6'(lowest(p));
        if (stk.size() == DEPTH) m_ovf = 1;
        else stk.push_back('{pc, m_mode, m_ie, c});
        m_mode = 0;
        m_ie = 0;
        m_cause = c;
        sb.push_back('{m_vec, 1'b0, 1'b0});
      end else if (mv && we) begin
        if (wa == 5'd1 && stk.size() != 0) begin
          f = stk.pop_back();
          f.epc = wd[31:2];
          stk.push_back(f);
        end
        if (wa == 5'd4) m_vec = wd[31:2];
        if (wa == 5'd5) m_mode = wd[0];
        if (wa == 5'd7) m_imask = wd[SRC_N-1:0];
        if (wa == 5'd9) begin
          m_ie = wd[0];
          m_ovf = m_ovf && wd[1];
        end
`ifdef YUTORINA_EXC_CTRL_TIMER_EN
        if (wa == 5'd10) begin
          m_cmp = wd;
          m_wcnt = m_cnt[31:0];
        end
`endif
        sb.push_back('{pc + 30'd1, 1'b0, m_mode});
      end
    end
    @(posedge clk);
    #1;
    d_busy = 0; eret = 0; mem_valid = 0; exp_code = 0; mem_pc = 0;
    irq = 0; spr_we = 0; w_addr = 0; w_data = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    m_mode = 0; m_ie = 0; m_ovf = 0; m_vec = 0; m_imask = 0; m_cause = 0; m_cmp = 0; m_wcnt = 0;
    stk.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  logic [4:0] wa_tbl [9] = '{5'd1, 5'd4, 5'd5, 5'd7, 5'd9, 5'd0, 5'd6, 5'd2, 5'd20};

  initial begin
    logic [4:0] a;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("reset_mode", {31'd0, mode}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    rd(5'd2, 32'd5);
    rd(5'd9, 32'd0);
    // vector, exception, ERET
    issue(0, 0, 1, 4'd0, 30'h10, 8'd0, 1, 5'd4, 32'h100);
    issue(0, 0, 1, 4'd3, 30'h40, 8'd0, 0, 5'd0, 32'd0);
    rd(5'd6, 32'd3);
    rd(5'd9, 32'h4);
    issue(0, 1, 0, 4'd0, 30'd0, 8'd0, 0, 5'd0, 32'd0);
    rd(5'd9, 32'd0);
    // interrupts
    issue(0, 0, 1, 4'd0, 30'h20, 8'd0, 1, 5'd7, 32'h0C);
    issue(0, 0, 1, 4'd0, 30'h21, 8'd0, 1, 5'd9, 32'h1);
    issue(0, 0, 1, 4'd0, 30'h55, 8'h0C, 0, 5'd0, 32'd0);
    rd(5'd6, 32'd18);
    rd(5'd9, 32'h4);
    issue(0, 1, 0, 4'd0, 30'd0, 8'd0, 0, 5'd0, 32'd0);
    rd(5'd9, 32'h1);
    issue(0, 0, 1, 4'd0, 30'h22, 8'd0, 1, 5'd7, 32'h0);
    issue(0, 0, 1, 4'd0, 30'h56, 8'hFF, 0, 5'd0, 32'd0);
    rd(5'd8, 32'd0);
    // nesting and overflow
    for (int i = 1; i <= 5; i++) issue(0, 0, 1, 4'd5, 30'(i), 8'd0, 0, 5'd0, 32'd0);
    rd(5'd9, 32'h12);
    for (int i = 0; i < 5; i++) issue(0, 1, 0, 4'd0, 30'd0, 8'd0, 0, 5'd0, 32'd0);
    rd(5'd9, 32'h3);
    // ERET beats a same-cycle exception
    issue(0, 0, 1, 4'd1, 30'h77, 8'd0, 0, 5'd0, 32'd0);
    issue(0, 1, 1, 4'd2, 30'h99, 8'd0, 0, 5'd0, 32'd0);
    rd(5'd9, m_spr(5'd9));
    chk("eret_priority_sp", m_spr(5'd9) & 32'h1C, 32'd0);
    // stall holds off the exception
    d_busy = 1;
    #1 chk("stall_out", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 1, 4'd4, 30'h31, 8'd0, 0, 5'd0, 32'd0);
      chk("stalled_no_flush", {31'd0, flush}, 32'd0);
    end
    issue(0, 0, 1, 4'd4, 30'h31, 8'd0, 0, 5'd0, 32'd0);
    rd(5'd6, 32'd4);
    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      issue($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 15)) : 4'd0, 30'($urandom),
            8'($urandom), 1'($urandom), wa_tbl[$urandom_range(0, 8)], $urandom);
      if ($urandom_range(0, 2) == 0) begin
        a = 5'($urandom_range(0, 11));
        rd(a, m_spr(a));
      end
    end
`ifdef YUTORINA_EXC_CTRL_TIMER_EN
    issue(0, 0, 1, 4'd0, 30'h60, 8'd0, 1, 5'd7, 32'h100);
    issue(0, 0, 1, 4'd0, 30'h61, 8'd0, 1, 5'd9, 32'h1);
    issue(0, 0, 1, 4'd0, 30'h62, 8'd0, 1, 5'd10, m_cnt[31:0] + 32'd20);
    repeat (25) @(posedge clk);
    #1;
    rd(5'd8, 32'h100);
    issue(0, 0, 1, 4'd0, 30'h66, 8'd0, 0, 5'd0, 32'd0);
    rd(5'd6, 32'd24);
`endif
    // reset during a flush
    issue(0, 0, 1, 4'd0, 30'h123, 8'd0, 1, 5'd5, 32'h1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_id_flush", {31'd0, id_flush}, 32'd0);
    chk("rst_new_pc", {2'b00, new_pc}, 32'd0);
    chk("rst_mode", {31'd0, mode}, 32'd0);
    do_reset();
    rd(5'd9, 32'd0);
    rd(5'd4, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/yutorina_exc_ctrl.md
Name: yutorina_exc_ctrl

Overview:
Parametrised next-generation CPU control unit for the Yutorina pipeline. It handles synchronous exceptions, masked external interrupts and ERET, and supports nested exceptions through a hardware EPC/mode/cause stack of configurable depth. It also owns the special-purpose register (SPR) file, including a free-running cycle counter. It sits beside the pipeline, takes exception and SPR traffic from the MEM stage and ERET from the ID stage, and drives flush, redirect PC and privilege mode.

Parameters:
ADDR_W, 30, word-address width of PCs and vector
DATA_W, 32, SPR data width
IRQ_N, 8, number of external interrupt lines (1..16)
DEPTH, 4, exception-stack depth (power of 2, >=2)
CNT_W, 64, cycle-counter width (DATA_W < CNT_W <= 2*DATA_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_busy  in  1  fetch stall request
d_busy  in  1  data stall request
eret  in  1  ERET valid in ID stage
mem_valid  in  1  MEM-stage instruction valid
exp_code  in  4  MEM-stage exception code; 0 means none
mem_pc  in  ADDR_W  MEM-stage instruction PC
irq  in  IRQ_N  level-sensitive interrupt lines
spr_we  in  1  SPR write strobe from MEM stage
w_addr  in  5  SPR write address
w_data  in  DATA_W  SPR write data
r_addr  in  5  SPR read address
r_data  out  DATA_W  SPR read data, combinational
stall  out  1  i_busy | d_busy
flush  out  1  full-pipeline flush, 1-cycle pulse
id_flush  out  1  ID-stage flush, 1-cycle pulse (ERET only)
new_pc  out  ADDR_W  redirect target, valid while flush=1
mode  out  1  0 = kernel, 1 = user

Behaviour:
- Reset values: flush=0, id_flush=0, new_pc=0, mode=kernel, cnt=0, vector=0, imask=0, ie=0, sp=0, ovf=0, cause=0.
- cnt increments every cycle except during rst, including while stalled.
- While stall=1, all other state is frozen and flush/id_flush are held at 0.
- Event priority per cycle, highest first: ERET, sync exception, interrupt, SPR write. Only one event is taken per cycle.
- ERET:
  - Pop the top frame. mode <= frame.mode, ie <= frame.ie, new_pc <= frame.epc, cause <= next-lower frame.cause, or 0 if none.
  - flush=1 and id_flush=1 next cycle.
  - On an empty stack: new_pc=0, mode=kernel, no pop.
- Sync exception (mem_valid & exp_code!=0):
  - Push {mem_pc, mode, ie, cause=exp_code}.
  - mode <= kernel, ie <= 0, new_pc <= vector, flush=1.
- Interrupt (mem_valid & exp_code==0 & ie & |(irq & imask)):
  - Take the lowest set index k.
  - Push {mem_pc, mode, ie, cause=16+k}; then behave exactly as a sync exception.
- Stack full on push: frame is dropped, ovf set (sticky until software writes STATUS), vector redirect still occurs. The existing frames are preserved.
- SPR write (mem_valid & spr_we, no higher-priority event):
  - Update the addressed writable SPR.
  - flush=1, new_pc=mem_pc+1 (restart after the writer).
  - Writes to read-only or unmapped addresses are ignored but still flush.
- No event: flush=0, id_flush=0, new_pc=0.
- SPR map:
  - 0 PC = {mem_pc,00}, RO
  - 1 EPC = top-frame epc,00, RW (writes the top frame)
  - 2 CNT_L, RO
  - 3 CNT_H = cnt[CNT_W-1:DATA_W], zero-extended, RO
  - 4 VECTOR, RW, low 2 bits ignored
  - 5 MODE = bit0, RW
  - 6 CAUSE, RO
  - 7 IMASK, RW, IRQ_N bits
  - 8 IPEND = irq & imask, RO
  - 9 STATUS = {sp, ovf, ie}, low bits; writable bits are ie (bit0) and ovf (bit1, clear-only)
  - 10 CMP, present only with the optional feature
  - Unmapped addresses read 0.
- Stack pointer arithmetic: 0..DEPTH with no wrap. sp==DEPTH means full, sp==0 means empty.
- Reset asserted mid-flush: all outputs return to their reset values on the next edge.

Optional Feature:
- Macro: YUTORINA_EXC_CTRL_TIMER_EN.
- When defined:
  - SPR 10 is CMP, DATA_W bits, RW, reset 0.
  - A timer-pending bit sets when cnt[DATA_W-1:0]==CMP and CMP!=0. It clears on a write to CMP.
  - The timer acts as interrupt channel IRQ_N, at lowest priority, cause 16+IRQ_N, gated by imask bit IRQ_N (IMASK widens to IRQ_N+1 bits).
- When undefined: SPR 10 reads 0, writes are ignored, no timer logic exists.

Test Plan:
- Reset, then 5 idle cycles: mode=0, flush=0, CNT_L=5, r_addr=9 reads 0.
- Write VECTOR=0x100. Then exp_code=3 at mem_pc=0x40: next cycle flush=1, new_pc=0x40, mode=0, CAUSE=3, STATUS.sp=1. Then ERET: flush=1, id_flush=1, new_pc=0x40.
- imask=0x0C, ie=1, irq=0x0C: taken cause=18 (lowest index), ie=0. irq with imask=0: no flush.
- DEPTH=4, five nested exceptions with PCs 1..5: fifth sets ovf=1 and still redirects to vector. Four ERETs return 4,3,2,1; a fifth ERET returns new_pc=0.
- Assert ERET and exp_code=2 in the same cycle: ERET wins, no push. Hold d_busy=1 during an exception: no flush until d_busy drops.
- With YUTORINA_EXC_CTRL_TIMER_EN: CMP=20, imask bit IRQ_N=1, ie=1: interrupt taken with cause 16+IRQ_N once cnt reaches 20.
